// File: rtl/snax_dream_job_ctrl.sv
// -----------------------------------------------------------------------------
// snax_dream_job_ctrl
//
// Job controller sitting directly behind the DREAM CSR manager. A job is
// configured through the packed read-write CSR set and started by a
// valid/ready handshake. The job then emits a strided stream of address
// requests while keeping the number of in-flight requests (issued but not
// yet answered) bounded. Status and the duration of the last job are fed
// back to the manager through the packed read-only CSR set.
//
// Parameters
//   NumRwCsr        number of packed RW CSRs presented (indices 0..2 used)
//   NumRoCsr        number of packed RO CSRs produced (indices 0..1 driven)
//   MaxOutstanding  in-flight request bound, 1..255
//
// Ports
//   clk_i                rising-edge clock
//   rst_i                asynchronous active-high reset
//   csr_reg_rw_set_i     [0] length in beats, [1] base address, [2] stride
//   csr_reg_set_valid_i  configuration valid
//   csr_reg_set_ready_o  configuration ready (only while idle)
//   csr_reg_ro_set_o     [0] status, [1] cycle count of last job, rest 0
//                        status: [0] busy, [1] done_sticky,
//                                [15:8] outstanding, [31:16] job count
//   req_addr_o           request address
//   req_valid_o          request valid
//   req_ready_i          request ready
//   rsp_valid_i          response beat (always accepted)
//   rsp_ready_o          constant 1
//   done_o               single-cycle pulse after job completion
// -----------------------------------------------------------------------------
module snax_dream_job_ctrl #(
    parameter int unsigned NumRwCsr       = 3,
    parameter int unsigned NumRoCsr       = 2,
    parameter int unsigned MaxOutstanding = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NumRwCsr-1:0][31:0]  csr_reg_rw_set_i,
    input  logic                       csr_reg_set_valid_i,
    output logic                       csr_reg_set_ready_o,
    output logic [NumRoCsr-1:0][31:0]  csr_reg_ro_set_o,
    output logic [31:0]                req_addr_o,
    output logic                       req_valid_o,
    input  logic                       req_ready_i,
    input  logic                       rsp_valid_i,
    output logic                       rsp_ready_o,
    output logic                       done_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam logic [7:0] MaxOut = 8'(MaxOutstanding);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e      state_q,       state_d;
    logic [31:0] len_q,         len_d;
    logic [31:0] stride_q,      stride_d;
    logic [31:0] addr_q,        addr_d;
    logic [31:0] issued_q,      issued_d;
    logic [31:0] received_q,    received_d;
    logic [7:0]  outstanding_q, outstanding_d;
    logic [31:0] cycle_q,       cycle_d;
    logic [31:0] last_cycles_q, last_cycles_d;
    logic        done_sticky_q, done_sticky_d;
    logic [15:0] job_cnt_q,     job_cnt_d;
    logic        done_q,        done_d;
    logic        req_valid_q,   req_valid_d;
    logic        cfg_ready_q,   cfg_ready_d;
    logic [31:0] status_q,      status_d;

    logic        cfg_accept;
    logic        req_hs;
    logic        rsp_take;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        stride_d      = stride_q;
        addr_d        = addr_q;
        issued_d      = issued_q;
        received_d    = received_q;
        outstanding_d = outstanding_q;
        cycle_d       = cycle_q;
        last_cycles_d = last_cycles_q;
        done_sticky_d = done_sticky_q;
        job_cnt_d     = job_cnt_q;
        done_d        = 1'b0;

        // Ready is a registered decode of "idle", so accept never depends
        // combinationally on valid.
        cfg_accept = csr_reg_set_valid_i && cfg_ready_q;
        req_hs     = req_valid_q && req_ready_i;
        // Stray responses (nothing in flight, or no job) are dropped so the
        // counters can never underflow.
        rsp_take   = rsp_valid_i && (state_q != IDLE) && (outstanding_q != '0);

        // Busy-cycle counter, saturating.
        if ((state_q != IDLE) && (cycle_q != '1)) begin
            cycle_d = cycle_q + 32'd1;
        end

        unique case (state_q)
            IDLE: begin
                if (cfg_accept) begin
                    len_d         = csr_reg_rw_set_i[0];
                    addr_d        = csr_reg_rw_set_i[1];
                    stride_d      = csr_reg_rw_set_i[2];
                    issued_d      = '0;
                    received_d    = '0;
                    outstanding_d = '0;
                    cycle_d       = '0;
                    done_sticky_d = 1'b0;
                    if (csr_reg_rw_set_i[0] == '0) begin
                        // Empty job completes immediately without leaving idle.
                        last_cycles_d = '0;
                        done_sticky_d = 1'b1;
                        done_d        = 1'b1;
                        job_cnt_d     = job_cnt_q + 16'd1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end

            RUN, DRAIN: begin
                if (req_hs) begin
                    issued_d = issued_q + 32'd1;
                    addr_d   = addr_q + stride_q;
                end
                if (rsp_take) begin
                    received_d = received_q + 32'd1;
                end
                outstanding_d = outstanding_q + 8'(req_hs) - 8'(rsp_take);

                if ((state_q == RUN) && req_hs && (issued_d == len_q)) begin
                    state_d = DRAIN;
                end

                // Completion overrides the RUN->DRAIN move; cycle_d already
                // includes the current busy cycle.
                if (received_d == len_q) begin
                    state_d       = IDLE;
                    done_d        = 1'b1;
                    last_cycles_d = cycle_d;
                    done_sticky_d = 1'b1;
                    job_cnt_d     = job_cnt_q + 16'd1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered request valid. Without a handshake outstanding cannot
        // grow, so an asserted valid stays asserted until accepted.
        req_valid_d = (state_d == RUN) && (outstanding_d < MaxOut) &&
                      (issued_d != len_d);
        cfg_ready_d = (state_d == IDLE);
        status_d    = {job_cnt_d, outstanding_d, 6'd0, done_sticky_d,
                       (state_d != IDLE)};
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            len_q         <= '0;
            stride_q      <= '0;
            addr_q        <= '0;
            issued_q      <= '0;
            received_q    <= '0;
            outstanding_q <= '0;
            cycle_q       <= '0;
            last_cycles_q <= '0;
            done_sticky_q <= 1'b0;
            job_cnt_q     <= '0;
            done_q        <= 1'b0;
            req_valid_q   <= 1'b0;
            cfg_ready_q   <= 1'b1;
            status_q      <= '0;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            stride_q      <= stride_d;
            addr_q        <= addr_d;
            issued_q      <= issued_d;
            received_q    <= received_d;
            outstanding_q <= outstanding_d;
            cycle_q       <= cycle_d;
            last_cycles_q <= last_cycles_d;
            done_sticky_q <= done_sticky_d;
            job_cnt_q     <= job_cnt_d;
            done_q        <= done_d;
            req_valid_q   <= req_valid_d;
            cfg_ready_q   <= cfg_ready_d;
            status_q      <= status_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign csr_reg_set_ready_o = cfg_ready_q;
    assign req_addr_o          = addr_q;
    assign req_valid_o         = req_valid_q;
    assign rsp_ready_o         = 1'b1;
    assign done_o              = done_q;

    always_comb begin
        csr_reg_ro_set_o    = '0;
        csr_reg_ro_set_o[0] = status_q;
        csr_reg_ro_set_o[1] = last_cycles_q;
    end

`ifndef SYNTHESIS
    // A response with nothing in flight during a job points at a broken
    // requester; it is dropped by the logic above but flagged here.
    assert property (@(posedge clk_i) disable iff (rst_i)
        !(rsp_valid_i && (state_q != IDLE) && (outstanding_q == '0)))
        else $error("snax_dream_job_ctrl: response with no outstanding request");
`endif

endmodule

// File: tb/tb_snax_dream_job_ctrl.sv
module tb_snax_dream_job_ctrl;

    localparam int unsigned NUM_RW = 3;
    localparam int unsigned NUM_RO = 2;
    localparam int unsigned MAX    = 8;

    logic                     clk_i = 1'b0;
    logic                     rst_i = 1'b1;
    logic [NUM_RW-1:0][31:0]  cfg_set = '0;
    logic                     cfg_valid = 1'b0;
    logic                     cfg_ready;
    logic [NUM_RO-1:0][31:0]  ro;
    logic [31:0]              req_addr_o;
    logic                     req_valid_o;
    logic                     req_ready_i = 1'b1;
    logic                     rsp_valid_i = 1'b0;
    logic                     rsp_ready_o;
    logic                     done_o;

    snax_dream_job_ctrl #(
        .NumRwCsr       (NUM_RW),
        .NumRoCsr       (NUM_RO),
        .MaxOutstanding (MAX)
    ) dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .csr_reg_rw_set_i    (cfg_set),
        .csr_reg_set_valid_i (cfg_valid),
        .csr_reg_set_ready_o (cfg_ready),
        .csr_reg_ro_set_o    (ro),
        .req_addr_o          (req_addr_o),
        .req_valid_o         (req_valid_o),
        .req_ready_i         (req_ready_i),
        .rsp_valid_i         (rsp_valid_i),
        .rsp_ready_o         (rsp_ready_o),
        .done_o              (done_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Scoreboard queues: expected request addresses and expected status at done.
    logic [31:0] exp_addr[$];
    logic [31:0] exp_done[$];
    logic [15:0] jobs = '0;

    // Environment controls (written by the stimulus process only).
    int ready_mode  = 0;   // 0: always ready, 1: random
    int rsp_mode    = 0;   // 0: answer asap, 1: withhold, 2: random
    int release_req = 0;
    logic inject_rsp = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // -------------------------------------------------------------------------
    // Environment: request ready and responder
    // -------------------------------------------------------------------------
    int pending     = 0;
    int release_ack = 0;
    always @(posedge clk_i) begin
        if (rst_i) begin
            pending     = 0;
            rsp_valid_i = 1'b0;
            release_ack = release_req;
        end else begin
            if (req_valid_o && req_ready_i) pending++;
            if (rsp_valid_i && pending > 0) pending--;
            #1;
            req_ready_i = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            rsp_valid_i = 1'b0;
            if (inject_rsp) begin
                rsp_valid_i = 1'b1;
            end else if (pending > 0) begin
                if (rsp_mode == 0) rsp_valid_i = 1'b1;
                else if (rsp_mode == 2) rsp_valid_i = ($urandom_range(0, 2) != 0);
                else if (release_req != release_ack) begin
                    rsp_valid_i = 1'b1;
                    release_ack++;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Monitor with transaction-level reference model
    // -------------------------------------------------------------------------
    logic        m_busy = 1'b0, m_run = 1'b0, m_sticky = 1'b0;
    logic [31:0] m_len = '0, m_issued = '0, m_recv = '0, m_last = '0;
    logic [15:0] m_jobcnt = '0;
    int          m_out = 0, m_start = 0, m_done_at = -1;

    always @(negedge clk_i) begin
        logic        exp_valid, hs, rsp;
        logic [31:0] exp_ro0, rec;
        if (rst_i) begin
            m_busy = 1'b0; m_run = 1'b0; m_sticky = 1'b0; m_out = 0;
            m_last = '0; m_jobcnt = '0; m_done_at = -1;
            chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
            chk("rst_req_valid", 32'(req_valid_o), 32'd0);
            chk("rst_done", 32'(done_o), 32'd0);
            chk("rst_ro0", ro[0], 32'd0);
            chk("rst_ro1", ro[1], 32'd0);
        end else begin
            exp_valid = m_run && (m_out < int'(MAX));
            exp_ro0   = {m_jobcnt, 8'(m_out), 6'd0, m_sticky, m_busy};
            chk("req_valid", 32'(req_valid_o), 32'(exp_valid));
            chk("cfg_ready", 32'(cfg_ready), 32'(!m_busy));
            chk("status", ro[0], exp_ro0);
            chk("last_cycles", ro[1], m_last);
            chk("rsp_ready", 32'(rsp_ready_o), 32'd1);
            chk("done_pulse", 32'(done_o), 32'(cyc == m_done_at));
            if (done_o) begin
                chk("done_expected", 32'(exp_done.size() != 0), 32'd1);
                if (exp_done.size() != 0) begin
                    rec = exp_done.pop_front();
                    chk("done_status", ro[0], rec);
                end
            end
            if (req_valid_o) begin
                chk("req_expected", 32'(exp_addr.size() != 0), 32'd1);
                if (exp_addr.size() != 0) begin
                    chk("req_addr", req_addr_o, exp_addr[0]);
                    if (req_ready_i) void'(exp_addr.pop_front());
                end
            end

            // Advance the model across the coming edge.
            hs  = exp_valid && req_ready_i;
            rsp = rsp_valid_i && m_busy && (m_out > 0);
            if (!m_busy) begin
                if (cfg_valid) begin
                    m_sticky = 1'b0;
                    if (cfg_set[0] == 32'd0) begin
                        m_last    = '0;
                        m_sticky  = 1'b1;
                        m_jobcnt  = m_jobcnt + 16'd1;
                        m_done_at = cyc + 1;
                    end else begin
                        m_busy   = 1'b1;
                        m_run    = 1'b1;
                        m_len    = cfg_set[0];
                        m_issued = '0;
                        m_recv   = '0;
                        m_out    = 0;
                        m_start  = cyc;
                    end
                end
            end else begin
                if (hs) begin m_issued++; m_out++; end
                if (rsp) begin m_recv++; m_out--; end
                if (m_issued == m_len) m_run = 1'b0;
                if (m_recv == m_len) begin
                    m_busy    = 1'b0;
                    m_run     = 1'b0;
                    m_sticky  = 1'b1;
                    m_jobcnt  = m_jobcnt + 16'd1;
                    m_last    = 32'(cyc - m_start);
                    m_done_at = cyc + 1;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    task automatic start_job(input logic [31:0] len, input logic [31:0] base,
                             input logic [31:0] stride);
        int n;
        jobs = jobs + 16'd1;
        for (int unsigned k = 0; k < len; k++) exp_addr.push_back(base + k * stride);
        exp_done.push_back({jobs, 16'h0002});
        @(posedge clk_i); #1;
        cfg_set[0] = len;
        cfg_set[1] = base;
        cfg_set[2] = stride;
        cfg_valid  = 1'b1;
        n = 0;
        while (n < 20) begin
            @(negedge clk_i);
            if (cfg_ready) break;
            n++;
        end
        chk("cfg_accept_in_budget", 32'(n < 20), 32'd1);
        @(posedge clk_i); #1;
        cfg_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (n < budget) begin
            @(negedge clk_i);
            if (done_o) break;
            n++;
        end
        chk("job_done_in_budget", 32'(n < budget), 32'd1);
    endtask

    task automatic apply_reset();
        @(posedge clk_i); #3;
        rst_i = 1'b1;
        #1;
        chk("areset_cfg_ready", 32'(cfg_ready), 32'd1);
        chk("areset_req_valid", 32'(req_valid_o), 32'd0);
        chk("areset_req_addr", req_addr_o, 32'd0);
        chk("areset_done", 32'(done_o), 32'd0);
        chk("areset_rsp_ready", 32'(rsp_ready_o), 32'd1);
        chk("areset_ro0", ro[0], 32'd0);
        chk("areset_ro1", ro[1], 32'd0);
        exp_addr.delete();
        exp_done.delete();
        jobs = '0;
        repeat (2) @(posedge clk_i);
        #3 rst_i = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk_i);
        #3 rst_i = 1'b0;

        // Idle after reset.
        repeat (3) @(negedge clk_i);
        chk("idle_ready", 32'(cfg_ready), 32'd1);
        chk("idle_ro0", ro[0], 32'd0);
        chk("idle_ro1", ro[1], 32'd0);
        chk("idle_valid", 32'(req_valid_o), 32'd0);
        chk("idle_addr", req_addr_o, 32'd0);

        // Basic strided job.
        start_job(32'd4, 32'h0000_1000, 32'h10);
        wait_done(100);
        chk("basic_ro0", ro[0], 32'h0001_0002);
        chk("basic_ro1", ro[1], 32'd5);

        // Outstanding bound with withheld responses.
        rsp_mode = 1;
        start_job(32'd20, 32'h2000_0000, 32'h4);
        repeat (15) @(negedge clk_i);
        chk("withhold_issued", 32'(20 - exp_addr.size()), 32'd8);
        chk("withhold_valid", 32'(req_valid_o), 32'd0);
        chk("withhold_outstanding", 32'(ro[0][15:8]), 32'd8);
        for (int i = 0; i < 3; i++) begin
            release_req++;
            repeat (4) @(negedge clk_i);
            chk("release_issued", 32'(20 - exp_addr.size()), 32'(9 + i));
            chk("release_outstanding", 32'(ro[0][15:8]), 32'd8);
        end
        rsp_mode = 0;
        wait_done(200);

        // Random ready / responses, three back-to-back jobs from a clean count.
        apply_reset();
        ready_mode = 1;
        rsp_mode   = 2;
        for (int j = 0; j < 3; j++) begin
            start_job(32'($urandom_range(1, 12)), $urandom, $urandom);
            wait_done(400);
        end
        chk("job_cnt_three", 32'(ro[0][31:16]), 32'd3);

        for (int j = 0; j < 6; j++) begin
            ready_mode = int'($urandom_range(0, 1));
            rsp_mode   = (j % 2 == 0) ? 2 : 0;
            start_job(32'($urandom_range(1, 20)), $urandom, $urandom);
            wait_done(600);
        end

        // Zero-length job.
        ready_mode = 0;
        rsp_mode   = 0;
        start_job(32'd0, 32'h1234_5678, 32'h4);
        wait_done(10);
        chk("len0_ro1", ro[1], 32'd0);
        chk("len0_ready", 32'(cfg_ready), 32'd1);
        chk("len0_valid", 32'(req_valid_o), 32'd0);

        // Address wrap.
        start_job(32'd2, 32'hFFFF_FFF0, 32'h20);
        wait_done(50);

        // Reset while draining with three outstanding.
        rsp_mode = 1;
        start_job(32'd3, 32'h0000_8000, 32'h8);
        repeat (5) @(negedge clk_i);
        chk("drain_outstanding", 32'(ro[0][15:8]), 32'd3);
        chk("drain_busy", 32'(ro[0][0]), 32'd1);
        chk("drain_valid", 32'(req_valid_o), 32'd0);
        apply_reset();
        rsp_mode = 0;
        @(negedge clk_i);
        inject_rsp = 1'b1;
        @(negedge clk_i);
        inject_rsp = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("late_rsp_ro0", ro[0], 32'd0);
        chk("late_rsp_ro1", ro[1], 32'd0);
        start_job(32'd4, 32'h0000_1000, 32'h10);
        wait_done(100);
        chk("post_reset_ro0", ro[0], 32'h0001_0002);
        chk("post_reset_ro1", ro[1], 32'd5);

        repeat (3) @(negedge clk_i);
        chk("addr_queue_empty", 32'(exp_addr.size()), 32'd0);
        chk("done_queue_empty", 32'(exp_done.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/snax_dream_job_ctrl.md
# snax_dream_job_ctrl

Job controller directly downstream of the DREAM CSR manager. It consumes the packed read-write CSR set through a valid/ready handshake and runs one job: a strided address-request stream with bounded outstanding responses. It feeds status and performance counters back to the manager's read-only CSR inputs.

## Interface
Parameters:
- NumRwCsr, 3, number of packed RW CSRs consumed; indices 0..2 are used.
- NumRoCsr, 2, number of packed RO CSRs produced; indices 0..1 are driven.
- MaxOutstanding, 8, maximum in-flight requests without a response; must be ≥1 and ≤255.

Ports:
- clk_i  in  1  clock; all logic is on the rising edge.
- rst_i  in  1  asynchronous active-high reset.
- csr_reg_rw_set_i  in  NumRwCsr×32  config: [0] job length in beats, [1] base address, [2] byte stride.
- csr_reg_set_valid_i  in  1  config valid.
- csr_reg_set_ready_o  out  1  config accepted when valid && ready.
- csr_reg_ro_set_o  out  NumRoCsr×32  [0] status, [1] cycle count of the last job.
- req_addr_o  out  32  request address.
- req_valid_o  out  1  request valid.
- req_ready_i  in  1  request ready.
- rsp_valid_i  in  1  response beat; always accepted.
- rsp_ready_o  out  1  tied to 1.
- done_o  out  1  one-cycle pulse at job completion.

## Operation
- States: IDLE, RUN, DRAIN.
- csr_reg_set_ready_o is 1 only in IDLE. It is decoded from the state register and has no combinational path from valid.
- On accept, the block latches len, base and stride. It clears issued, received and cycle counters and clears done_sticky.
  - If len==0: stay in IDLE, set ro[1]=0, set done_sticky, pulse done_o next cycle, increment job_cnt.
  - Otherwise go to RUN.
- RUN:
  - req_valid_o = (outstanding < MaxOutstanding).
  - req_addr_o = base + issued×stride, computed incrementally by adding stride on each request handshake. Arithmetic wraps mod 2^32.
  - Once valid is asserted, address and valid are held until ready.
  - After the handshake where issued reaches len, go to DRAIN.
- DRAIN: req_valid_o=0. Wait until received==len.
- Completion (received reaches len, in RUN or DRAIN):
  - done_o is 1 for the next cycle.
  - The state returns to IDLE on the same edge.
  - ro[1] latches the cycle count.
  - done_sticky is set and job_cnt increments (16-bit, wraps).
- outstanding = issued − received.
  - A request handshake and a response in the same cycle leave it unchanged.
  - A response arriving with outstanding==0, or while in IDLE, is ignored. Counters never underflow; a simulation assertion flags this case.
- Cycle counter: counts every cycle with state≠IDLE, saturating at 0xFFFF_FFFF.
- Status ro[0]: bit0 = busy (state≠IDLE), bit1 = done_sticky, bits[15:8] = outstanding, bits[31:16] = job_cnt, remaining bits 0.
- RW CSR indices ≥3 are ignored. RO indices ≥2 read 0.

## Timing
- Reset values: state=IDLE, csr_reg_set_ready_o=1, req_valid_o=0, req_addr_o=0, done_o=0, rsp_ready_o=1, ro[0]=0, ro[1]=0, all counters 0.
- Reset asserted mid-job aborts immediately. Responses that arrive after reset are ignored.
- The first request is valid in the cycle after the config handshake, with address = base.
- With req_ready_i=1 and no stall, the block issues one request per cycle.
- Status updates are registered and visible one cycle after the causing edge.
- For len=1, req_ready=1, and rsp one cycle after the request: accept, RUN (1 cycle), DRAIN (1 cycle with rsp), IDLE. ro[1]=2, and done_o is high in the first IDLE cycle.

## Test plan
- Reset then idle: ready=1, ro[0]=0, ro[1]=0, no requests.
- len=4, base=0x1000, stride=0x10, ready=1, rsp one cycle after each request:
  - addresses 0x1000, 0x1010, 0x1020, 0x1030 in 4 consecutive cycles;
  - one done_o pulse; ro[0]=0x0001_0002; ro[1]=5.
- len=20, MaxOutstanding=8, responses withheld: exactly 8 requests issued, then req_valid_o=0 with ro[0][15:8]=8. Each released response allows exactly one further request.
- req_ready_i toggled randomly: req_addr_o is held stable while valid && !ready; there are 3 back-to-back jobs and job_cnt reaches 3.
- len=0: no requests; done_o pulses; ro[1]=0; ready stays 1. base=0xFFFF_FFF0, stride=0x20, len=2: addresses 0xFFFF_FFF0, then 0x0000_0010.
- rst_i asserted in DRAIN with 3 outstanding: all outputs are at reset values in the same cycle. A late rsp_valid_i is ignored, and a new job then runs correctly.
